// File: rtl/mem_pkg.sv
// mem_pkg: shared state type, access-size encodings and defaults for the LSU memory responder
package mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_DEPTH = 256;
  function automatic logic size_illegal(input logic [2:0] size, input logic we);
    return !(size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU}) || (we && size[2]);
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane strobes, store data shift, load extraction/extension and misalign detection
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  strb,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic [31:0] sh;
  always_comb begin
    sh = word >> {off, 3'b000};
    strb = size[1:0] == 2'b00 ? 4'b0001 << off : size[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    wdata_sh = wdata << {off, 3'b000};
    misalign = size[1:0] == 2'b01 ? off[0] : size[1:0] == 2'b10 ? off != 2'b00 : 1'b0;
    rdata = size == SZ_B  ? {{24{sh[7]}}, sh[7:0]} :
            size == SZ_H  ? {{16{sh[15]}}, sh[15:0]} :
            size == SZ_BU ? {24'b0, sh[7:0]} :
            size == SZ_HU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: single-outstanding fixed-latency load/store responder over a word memory
module lsu_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_t state;
  logic [3:0] cnt;
  logic we_q;
  logic [2:0] size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, commit, err, misalign, a_we;
  logic [2:0] a_size;
  logic [31:0] a_addr, a_wdata, wdata_sh, ld;
  logic [3:0] strb;
  logic [AW-1:0] widx;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  always_comb begin
    accept = req_valid && state == IDLE;
    a_we = state == IDLE ? req_we : we_q;
    a_size = state == IDLE ? req_size : size_q;
    a_addr = state == IDLE ? req_addr : addr_q;
    a_wdata = state == IDLE ? req_wdata : wdata_q;
    widx = a_addr[AW+1:2];
    commit = state == BUSY ? cnt == 4'd1 : accept && LATENCY == 1;
    err = misalign || size_illegal(a_size, a_we) || {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
  end
  mem_align u_align (
    .size(a_size),
    .off(a_addr[1:0]),
    .wdata(a_wdata),
    .word(mem[widx]),
    .strb(strb),
    .wdata_sh(wdata_sh),
    .rdata(ld),
    .misalign(misalign)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        we_q <= req_we;
        size_q <= req_size;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        rsp_err <= err;
        rsp_rdata <= err || a_we ? '0 : ld;
      end
      case (state)
        IDLE: if (req_valid) begin
          if (LATENCY == 1) state <= RESP;
          else state <= BUSY;
          cnt <= 4'(LATENCY - 1);
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (commit && !reset && !err && a_we)
      for (int i = 0; i < 4; i++)
        if (strb[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
  end
endmodule
